// File: rtl/jtag_dpi_pkg.sv
// Shared types for the JTAG bit-bang sequencer: one-TCK command word and FSM states.
package jtag_dpi_pkg;

   typedef struct packed {
      logic tms;
      logic tdi;
      logic trst;
      logic capture;
   } jtag_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_WAIT_RSP
   } jtag_seq_state_e;

   // Pin levels held while the TAP is in reset and no command has been issued.
   localparam jtag_cmd_t CMD_RESET = '{tms: 1'b1, tdi: 1'b0, trst: 1'b0, capture: 1'b0};

endpackage

// File: rtl/jtag_cmd_fifo.sv
// Synchronous command FIFO of jtag_cmd_t; full blocks pushes, empty blocks pops.
module jtag_cmd_fifo
   import jtag_dpi_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  jtag_cmd_t din_i,
   input  logic      pop_i,
   output jtag_cmd_t dout_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   jtag_cmd_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            push_ok;
   logic            pop_ok;

   assign full_o  = (count == (AW+1)'(DEPTH));
   assign empty_o = (count == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = mem[rd_ptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= din_i;
   end

endmodule

// File: rtl/jtag_bitbang_seq.sv
// Buffered JTAG pin sequencer: each queued command yields one divided TCK cycle,
// with optional TDO capture returned through a single-entry response slot.
module jtag_bitbang_seq
   import jtag_dpi_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CLK_DIV    = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   input  logic cmd_valid_i,
   output logic cmd_ready_o,
   input  logic cmd_tms_i,
   input  logic cmd_tdi_i,
   input  logic cmd_trst_i,
   input  logic cmd_capture_i,
   output logic rsp_valid_o,
   input  logic rsp_ready_i,
   output logic rsp_tdo_o,
   output logic busy_o,
   output logic jtag_tck_o,
   output logic jtag_tms_o,
   output logic jtag_tdi_o,
   output logic jtag_trst_o,
   input  logic jtag_tdo_i
);

   localparam int unsigned     CW       = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0]   DIV_LOAD = CW'(CLK_DIV - 1);

   jtag_seq_state_e state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   jtag_cmd_t       pins_q, pins_d;
   logic            tck_q, tck_d;
   logic            tdo_q, tdo_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_tdo_q, rsp_tdo_d;
   logic            busy_q;

   jtag_cmd_t       fifo_din;
   jtag_cmd_t       fifo_dout;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;
   logic            can_pop;
   logic            slot_busy;
   logic            hi_exit;

   assign fifo_din = '{tms: cmd_tms_i, tdi: cmd_tdi_i, trst: cmd_trst_i, capture: cmd_capture_i};

   jtag_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (cmd_valid_i),
      .din_i   (fifo_din),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign can_pop   = enable_i && !fifo_empty;
   // Slot counts as free if the consumer is taking the current entry this cycle.
   assign slot_busy = rsp_valid_q && !rsp_ready_i;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pins_d      = pins_q;
      tck_d       = tck_q;
      tdo_d       = tdo_q;
      rsp_valid_d = slot_busy;
      rsp_tdo_d   = rsp_tdo_q;
      fifo_pop    = 1'b0;
      hi_exit     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tck_d = 1'b0;
            if (can_pop) begin
               fifo_pop = 1'b1;
               pins_d   = fifo_dout;
               cnt_d    = DIV_LOAD;
               state_d  = ST_LOW;
            end
         end
         ST_LOW: begin
            if (cnt_q == '0) begin
               tck_d   = 1'b1;
               tdo_d   = jtag_tdo_i;
               cnt_d   = DIV_LOAD;
               state_d = ST_HIGH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HIGH: begin
            if (cnt_q == '0) hi_exit = 1'b1;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_WAIT_RSP: hi_exit = 1'b1;
         default:     state_d = ST_IDLE;
      endcase

      // Shared falling-edge actions for HIGH timeout and a released WAIT_RSP.
      if (hi_exit) begin
         if (pins_q.capture && slot_busy) begin
            state_d = ST_WAIT_RSP;
         end else begin
            tck_d = 1'b0;
            if (pins_q.capture) begin
               rsp_valid_d = 1'b1;
               rsp_tdo_d   = tdo_q;
            end
            if (can_pop) begin
               fifo_pop = 1'b1;
               pins_d   = fifo_dout;
               cnt_d    = DIV_LOAD;
               state_d  = ST_LOW;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pins_q      <= CMD_RESET;
         tck_q       <= 1'b0;
         tdo_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_tdo_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pins_q      <= pins_d;
         tck_q       <= tck_d;
         tdo_q       <= tdo_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tdo_q   <= rsp_tdo_d;
         busy_q      <= !fifo_empty || (state_q != ST_IDLE) || rsp_valid_q;
      end
   end

   assign cmd_ready_o = !fifo_full;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_tdo_o   = rsp_tdo_q;
   assign busy_o      = busy_q;
   assign jtag_tck_o  = tck_q;
   assign jtag_tms_o  = pins_q.tms;
   assign jtag_tdi_o  = pins_q.tdi;
   assign jtag_trst_o = pins_q.trst;

endmodule

// File: tb/tb_jtag_bitbang_seq.sv
// Directed bench for jtag_bitbang_seq: pacing, capture scoreboard, backpressure, full FIFO, reset.
module tb_jtag_bitbang_seq;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic enable_i;
   logic cmd_valid_i;
   logic cmd_ready_o;
   logic cmd_tms_i;
   logic cmd_tdi_i;
   logic cmd_trst_i;
   logic cmd_capture_i;
   logic rsp_valid_o;
   logic rsp_ready_i;
   logic rsp_tdo_o;
   logic busy_o;
   logic jtag_tck_o;
   logic jtag_tms_o;
   logic jtag_tdi_o;
   logic jtag_trst_o;
   logic jtag_tdo_i;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic        exp_q [$];

   int unsigned tck_rises = 0;
   int unsigned tck_falls = 0;
   int unsigned tdo_base  = 0;
   logic [7:0]  tdo_pat   = 8'hA5;
   logic [2:0]  tdo_idx;
   logic [3:0]  tms_seq   = 4'b0011;

   logic tck_s  [0:21];
   logic tms_s  [0:21];
   logic tdi_s  [0:21];
   logic trst_s [0:21];
   logic busy_s [0:21];

   always #5 clk_i = ~clk_i;

   always @(posedge jtag_tck_o) tck_rises <= tck_rises + 1;
   always @(negedge jtag_tck_o) tck_falls <= tck_falls + 1;

   // TAP model shifts the next 0xA5 bit (LSB first) out after every TCK fall.
   assign tdo_idx    = 3'(tck_falls - tdo_base);
   assign jtag_tdo_i = tdo_pat[tdo_idx];

   jtag_bitbang_seq #(
      .FIFO_DEPTH (8),
      .CLK_DIV    (2)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .enable_i      (enable_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_tms_i     (cmd_tms_i),
      .cmd_tdi_i     (cmd_tdi_i),
      .cmd_trst_i    (cmd_trst_i),
      .cmd_capture_i (cmd_capture_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_tdo_o     (rsp_tdo_o),
      .busy_o        (busy_o),
      .jtag_tck_o    (jtag_tck_o),
      .jtag_tms_o    (jtag_tms_o),
      .jtag_tdi_o    (jtag_tdi_o),
      .jtag_trst_o   (jtag_trst_o),
      .jtag_tdo_i    (jtag_tdo_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: score a response handshake at the falling edge, return 1 time unit after the rising edge.
   task automatic tick();
      @(negedge clk_i);
      if (rsp_valid_o && rsp_ready_i) begin
         check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("rsp_tdo", 32'(rsp_tdo_o), 32'(exp_q.pop_front()));
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_cmd(input logic v, input logic tms, input logic tdi, input logic trst, input logic cap);
      cmd_valid_i   = v;
      cmd_tms_i     = tms;
      cmd_tdi_i     = tdi;
      cmd_trst_i    = trst;
      cmd_capture_i = cap;
   endtask

   initial begin
      int unsigned r0;
      int unsigned r1;
      int unsigned f0;

      rst_ni      = 1'b0;
      enable_i    = 1'b0;
      rsp_ready_i = 1'b0;
      set_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk_i);
      #1;
      check("rst_tck",       32'(jtag_tck_o),  32'd0);
      check("rst_tms",       32'(jtag_tms_o),  32'd1);
      check("rst_tdi",       32'(jtag_tdi_o),  32'd0);
      check("rst_trst",      32'(jtag_trst_o), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_tdo",   32'(rsp_tdo_o),   32'd0);
      check("rst_busy",      32'(busy_o),      32'd0);
      rst_ni = 1'b1;
      tick();
      tick();

      // Back-to-back pacing, TMS = 1,1,0,0
      enable_i    = 1'b1;
      rsp_ready_i = 1'b1;
      for (int unsigned j = 0; j < 22; j++) begin
         if (j < 4) set_cmd(1'b1, tms_seq[j], j[0], 1'b1, 1'b0);
         else       set_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
         tck_s[j]  = jtag_tck_o;
         tms_s[j]  = jtag_tms_o;
         tdi_s[j]  = jtag_tdi_o;
         trst_s[j] = jtag_trst_o;
         busy_s[j] = busy_o;
      end
      for (int unsigned j = 0; j < 22; j++) begin
         check("pace_tck", 32'(tck_s[j]), 32'((j >= 1) && (j <= 16) && (((j - 1) % 4) >= 2)));
      end
      for (int unsigned j = 1; j <= 16; j++) begin
         check("pace_tms", 32'(tms_s[j]), 32'(tms_seq[(j - 1) / 4]));
         check("pace_tdi", 32'(tdi_s[j]), 32'(((j - 1) / 4) % 2));
      end
      check("pace_tms_pre",  32'(tms_s[0]),   32'd1);
      check("pace_trst_pre", 32'(trst_s[0]),  32'd0);
      check("pace_trst",     32'(trst_s[1]),  32'd1);
      check("pace_busy_run", 32'(busy_s[2]),  32'd1);
      check("pace_busy_end", 32'(busy_s[17]), 32'd1);
      check("pace_busy_off", 32'(busy_s[18]), 32'd0);

      // Capture of 0xA5 with a free-flowing response port
      tdo_base = tck_falls;
      for (int unsigned k = 0; k < 8; k++) begin
         set_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
         exp_q.push_back(tdo_pat[k]);
         tick();
      end
      set_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int unsigned i = 0; i < 80; i++) begin
         if (exp_q.size() == 0 && !rsp_valid_o) break;
         tick();
      end
      check("cap_drain",     32'(exp_q.size()),          32'd0);
      check("cap_rsp_valid", 32'(rsp_valid_o),           32'd0);
      check("cap_falls",     32'(tck_falls - tdo_base),  32'd8);

      // Response backpressure: second capture parks with TCK high
      rsp_ready_i = 1'b0;
      tdo_base    = tck_falls;
      r0          = tck_rises;
      for (int unsigned k = 0; k < 2; k++) begin
         set_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
         exp_q.push_back(tdo_pat[k]);
         tick();
      end
      set_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (16) tick();
      check("bp_tck_park",  32'(jtag_tck_o),         32'd1);
      check("bp_rises",     32'(tck_rises - r0),     32'd2);
      check("bp_rsp_valid", 32'(rsp_valid_o),        32'd1);
      check("bp_rsp_tdo",   32'(rsp_tdo_o),          32'd1);
      f0 = tck_falls;
      repeat (4) tick();
      check("bp_hold_falls", 32'(tck_falls - f0),    32'd0);
      check("bp_hold_tck",   32'(jtag_tck_o),        32'd1);
      rsp_ready_i = 1'b1;
      tick();
      check("bp_release_tck",   32'(jtag_tck_o),     32'd0);
      check("bp_release_valid", 32'(rsp_valid_o),    32'd1);
      check("bp_release_tdo",   32'(rsp_tdo_o),      32'd0);
      repeat (3) tick();
      check("bp_drain", 32'(exp_q.size()), 32'd0);

      // FIFO full with popping disabled
      enable_i = 1'b0;
      r0       = tck_rises;
      for (int unsigned k = 0; k < 9; k++) begin
         set_cmd(1'b1, k[0], 1'b0, 1'b1, 1'b0);
         check("full_ready", 32'(cmd_ready_o), 32'(k < 8));
         tick();
      end
      set_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("full_ready_after", 32'(cmd_ready_o),     32'd0);
      check("full_no_tck",      32'(tck_rises - r0),  32'd0);
      enable_i = 1'b1;
      for (int unsigned i = 0; i < 100; i++) begin
         tick();
         if (!busy_o) break;
      end
      check("full_pulses",    32'(tck_rises - r0), 32'd8);
      check("full_ready_end", 32'(cmd_ready_o),    32'd1);
      check("full_busy_end",  32'(busy_o),         32'd0);

      // Reset asserted while TCK is high for the second queued command
      rsp_ready_i = 1'b0;
      tdo_base    = tck_falls;
      r0          = tck_rises;
      set_cmd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      exp_q.push_back(tdo_pat[0]);
      tick();
      set_cmd(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      set_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int unsigned i = 0; i < 40; i++) begin
         if ((tck_rises - r0) == 2 && jtag_tck_o) break;
         tick();
      end
      check("mid_reach_high", 32'(tck_rises - r0), 32'd2);
      rst_ni = 1'b0;
      #1;
      check("mid_tck",       32'(jtag_tck_o),  32'd0);
      check("mid_tms",       32'(jtag_tms_o),  32'd1);
      check("mid_tdi",       32'(jtag_tdi_o),  32'd0);
      check("mid_trst",      32'(jtag_trst_o), 32'd0);
      check("mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("mid_cmd_ready", 32'(cmd_ready_o), 32'd1);
      check("mid_busy",      32'(busy_o),      32'd0);
      exp_q.delete();
      tick();
      tick();
      rst_ni = 1'b1;
      r1 = tck_rises;
      repeat (20) tick();
      check("mid_no_pulse", 32'(tck_rises - r1), 32'd0);
      check("mid_idle",     32'(busy_o),         32'd0);
      set_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      set_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int unsigned i = 0; i < 20; i++) begin
         if (tck_rises != r1) break;
         tick();
      end
      check("mid_new_pulse", 32'(tck_rises - r1), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
